// File: rtl/ifetch_prefetch_if.sv
// Instruction memory request/response channel.
// master = fetch side, slave = memory side.
interface ifetch_prefetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Sequential fetch prefetcher: credit-limited requests into an
// in-order FIFO of {pc, instr}, flushed by redirect.
module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    ifetch_prefetch_if.master            imem,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [31:0]                  instr_pc,
    output logic [31:0]                  instr,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] inflight_dec;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   pc_q  [DEPTH];
    logic [31:0]   ins_q [DEPTH];

    logic [CW:0]   credit;
    logic [31:0]   redirect_base;
    logic          req_fire;
    logic          resp_ok;
    logic          push;
    logic          pop;

    always_comb begin
        credit              = {1'b0, count} + {1'b0, inflight};
        redirect_base       = {redirect_pc[31:2], 2'b00};
        imem.imem_req_valid = !reset && !redirect
                              && (credit < (CW+1)'(DEPTH));
        imem.imem_req_addr  = reset ? RESET_PC : fetch_pc;
        req_fire            = imem.imem_req_valid && imem.imem_req_ready;
        // a response with nothing outstanding is ignored entirely
        resp_ok             = imem.imem_resp_valid && (inflight != '0);
        push                = resp_ok && (discard == '0) && !redirect;
        instr_valid         = !reset && !redirect && (count != '0);
        pop                 = instr_valid && instr_ready;
        instr_pc            = pc_q[head];
        instr               = ins_q[head];
        occupancy           = reset ? '0 : count;
        inflight_dec        = inflight - CW'(resp_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= inflight_dec;
            discard  <= inflight_dec;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= inflight_dec + CW'(req_fire);
            if (resp_ok && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_q[tail]  <= resp_pc;
            ins_q[tail] <= imem.imem_resp_data;
        end
    end
endmodule
